// File: rtl/can_tx_scheduler.sv
// Purpose : round-robin scheduler sharing one CAN transmit channel between NUM_REQ requesters,
//           with bounded retransmission and per-requester done/fail reporting.
// Latency : request seen in IDLE -> ack + start strobe next cycle; response -> retry strobe or
//           done/fail next cycle, arbitration again one cycle after that.
// Backpressure: a requester holds req_valid_i until req_ack_o; only one frame is in flight.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_valid_i/_data_i   per-requester pending flag and 64-bit payload (bits [64k+63:64k])
//   req_ack_o             one-cycle pulse when requester k's payload is latched
//   done_o / fail_o       one-cycle per-requester completion / drop pulses
//   busy_o                high whenever the scheduler is not idle
//   tx_data_o             payload held for can_simple_top
//   tx_start_strobe_o     one-cycle start pulse for can_simple_top
//   tx_succeed_i/failed_i result pulses from can_simple_top (honoured only while waiting)
//
// Optional feature: define CAN_TX_SCHED_TIMEOUT_EN to build a WAIT-state watchdog that treats
// TIMEOUT_CYC cycles without a response as a failed attempt.

module can_tx_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [NUM_REQ*64-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]     req_ack_o,
   output logic [NUM_REQ-1:0]     done_o,
   output logic [NUM_REQ-1:0]     fail_o,
   output logic                   busy_o,
   output logic [63:0]            tx_data_o,
   output logic                   tx_start_strobe_o,
   input  logic                   tx_succeed_i,
   input  logic                   tx_failed_i
);

   localparam int             GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0]     MAX_RETRY_L = 4'(MAX_RETRY);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [GW-1:0]        last_grant_q, last_grant_d;
   logic [3:0]           retry_q, retry_d;
   logic [63:0]          data_q, data_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [NUM_REQ-1:0]   fail_q, fail_d;
   logic                 strobe_q, strobe_d;
   logic                 busy_q, busy_d;

   logic                 arb_found;
   logic [GW-1:0]        arb_idx;
   logic [63:0]          sel_data;
   logic                 tmo_hit;
   logic                 attempt_failed;

   // Round-robin search starting just above the previous grant.
   always_comb begin
      int            cand;
      logic [GW-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(last_grant_q) + i) % NUM_REQ;
         cand_idx = GW'(cand);
         if (!arb_found && req_valid_i[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   // Payload of the requester about to be granted.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arb_idx == GW'(k)) begin
            sel_data = req_data_i[64*k +: 64];
         end
      end
   end

`ifdef CAN_TX_SCHED_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

   logic [31:0] tmo_q, tmo_d;

   // Cleared in START so each attempt gets a full window; counts only while waiting.
   always_comb begin
      tmo_d   = tmo_q;
      tmo_hit = 1'b0;
      if (state_q == ST_START) begin
         tmo_d = '0;
      end else if (state_q == ST_WAIT) begin
         if (tmo_q == TMO_LAST) begin
            tmo_hit = 1'b1;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic tmo_unused;
   assign tmo_unused = |32'(TIMEOUT_CYC);
   assign tmo_hit    = 1'b0;
`endif

   assign attempt_failed = tx_failed_i | tmo_hit;

   // Next state and next registered outputs; every output pulse is decided one cycle early
   // so that nothing on the output side is combinational from the inputs.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      retry_d      = retry_q;
      data_d       = data_q;
      ack_d        = '0;
      done_d       = '0;
      fail_d       = '0;
      strobe_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               grant_d        = arb_idx;
               data_d         = sel_data;
               retry_d        = '0;
               ack_d[arb_idx] = 1'b1;
               strobe_d       = 1'b1;
               state_d        = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Success takes priority over a coincident failure or timeout.
            if (tx_succeed_i) begin
               done_d[grant_q] = 1'b1;
               state_d         = ST_REPORT;
            end else if (attempt_failed) begin
               if (retry_q < MAX_RETRY_L) begin
                  retry_d  = retry_q + 4'd1;
                  strobe_d = 1'b1;
                  state_d  = ST_START;
               end else begin
                  fail_d[grant_q] = 1'b1;
                  state_d         = ST_REPORT;
               end
            end
         end
         ST_REPORT: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         retry_q      <= '0;
         data_q       <= '0;
         ack_q        <= '0;
         done_q       <= '0;
         fail_q       <= '0;
         strobe_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         retry_q      <= retry_d;
         data_q       <= data_d;
         ack_q        <= ack_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         strobe_q     <= strobe_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ack_o         = ack_q;
   assign done_o            = done_q;
   assign fail_o            = fail_q;
   assign busy_o            = busy_q;
   assign tx_data_o         = data_q;
   assign tx_start_strobe_o = strobe_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Purpose : directed self-checking bench for can_tx_scheduler (NUM_REQ=4, MAX_RETRY=3).
// Latency : expectations written against the one-cycle registered response of the scheduler.
// Backpressure: the bench plays both the requesters and can_simple_top.

module tb_can_tx_scheduler;

   localparam int NR = 4;

   logic              clk_i = 1'b0;
   logic              rst_n_i;
   logic [NR-1:0]     req_valid_i;
   logic [NR*64-1:0]  req_data_i;
   logic [NR-1:0]     req_ack_o;
   logic [NR-1:0]     done_o;
   logic [NR-1:0]     fail_o;
   logic              busy_o;
   logic [63:0]       tx_data_o;
   logic              tx_start_strobe_o;
   logic              tx_succeed_i;
   logic              tx_failed_i;

   can_tx_scheduler #(
      .NUM_REQ    (NR),
      .MAX_RETRY  (3),
      .TIMEOUT_CYC(100)
   ) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .req_valid_i       (req_valid_i),
      .req_data_i        (req_data_i),
      .req_ack_o         (req_ack_o),
      .done_o            (done_o),
      .fail_o            (fail_o),
      .busy_o            (busy_o),
      .tx_data_o         (tx_data_o),
      .tx_start_strobe_o (tx_start_strobe_o),
      .tx_succeed_i      (tx_succeed_i),
      .tx_failed_i       (tx_failed_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   int n_strobe = 0, n_ack = 0, n_done = 0, n_fail = 0;
   int b_strobe, b_ack, b_done, b_fail;
   int ack_log[$];

   logic [63:0] pay [NR];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse counters sampled mid-cycle; only read by the stimulus while the DUT is idle.
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (tx_start_strobe_o) n_strobe++;
         if (|done_o) n_done++;
         if (|fail_o) n_fail++;
         for (int k = 0; k < NR; k++) begin
            if (req_ack_o[k]) begin
               n_ack++;
               ack_log.push_back(k);
            end
         end
      end
   end

   task automatic snap();
      b_strobe = n_strobe;
      b_ack    = n_ack;
      b_done   = n_done;
      b_fail   = n_fail;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk_i);
   endtask

   task automatic check_counts(input string tag, input int s, input int a, input int d, input int f);
      check({tag, "_strobes"}, 64'(n_strobe - b_strobe), 64'(s));
      check({tag, "_acks"},    64'(n_ack - b_ack),       64'(a));
      check({tag, "_dones"},   64'(n_done - b_done),     64'(d));
      check({tag, "_fails"},   64'(n_fail - b_fail),     64'(f));
   endtask

   // Called at a negedge; returns at the next negedge, when the registered reaction is visible.
   task automatic pulse(input logic s, input logic f);
      tx_succeed_i = s;
      tx_failed_i  = f;
      @(negedge clk_i);
      tx_succeed_i = 1'b0;
      tx_failed_i  = 1'b0;
   endtask

   task automatic wait_strobe(input string tag);
      int n;
      n = 0;
      while (tx_start_strobe_o !== 1'b1 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      if (tx_start_strobe_o !== 1'b1) check({tag, "_timeout"}, 64'(tx_start_strobe_o), 64'd1);
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},    64'(req_ack_o),         64'd0);
      check({tag, "_done"},   64'(done_o),            64'd0);
      check({tag, "_fail"},   64'(fail_o),            64'd0);
      check({tag, "_busy"},   64'(busy_o),            64'd0);
      check({tag, "_data"},   tx_data_o,              64'd0);
      check({tag, "_strobe"}, 64'(tx_start_strobe_o), 64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i      = 1'b0;
      req_valid_i  = '0;
      tx_succeed_i = 1'b0;
      tx_failed_i  = 1'b0;
      pay[0] = 64'h0123_4567_89AB_CDEF;
      pay[1] = 64'h1111_2222_3333_4444;
      pay[2] = 64'hDEAD_BEEF_CAFE_F00D;
      pay[3] = 64'hA5A5_5A5A_0F0F_F0F0;
      req_data_i = {pay[3], pay[2], pay[1], pay[0]};

      // Reset values
      repeat (3) @(negedge clk_i);
      check_all_zero("rst");
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // Single frame from requester 0, success 10 cycles after the strobe
      snap();
      req_valid_i = 4'b0001;
      @(negedge clk_i);
      check("t1_ack",    64'(req_ack_o),         64'h1);
      check("t1_strobe", 64'(tx_start_strobe_o), 64'h1);
      check("t1_data",   tx_data_o,              pay[0]);
      req_valid_i = 4'b0000;
      repeat (9) @(negedge clk_i);
      check("t1_busy_wait", 64'(busy_o),  64'h1);
      check("t1_data_hold", tx_data_o,    pay[0]);
      pulse(1'b1, 1'b0);
      check("t1_done", 64'(done_o), 64'h1);
      check("t1_fail", 64'(fail_o), 64'h0);
      settle();
      check("t1_idle_busy", 64'(busy_o), 64'h0);
      check("t1_data_kept", tx_data_o,   pay[0]);
      check_counts("t1", 1, 1, 1, 0);

      // All four requesters held, continual success: order 0,1,2,3,0
      do_reset();
      ack_log.delete();
      snap();
      req_valid_i = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_strobe("t2_strobe");
         check($sformatf("t2_data%0d", f), tx_data_o, pay[f % 4]);
         @(negedge clk_i);
         pulse(1'b1, 1'b0);
         if (f == 4) req_valid_i = 4'b0000;
         check($sformatf("t2_done%0d", f), 64'(done_o), 64'd1 << (f % 4));
      end
      settle();
      check_counts("t2", 5, 5, 5, 0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t2_order%0d", i),
               (i < ack_log.size()) ? 64'(ack_log[i]) : 64'hFF, 64'(i % 4));
      end

      // Requester 2, every attempt fails: 4 strobes then fail
      snap();
      req_valid_i = 4'b0100;
      for (int a = 0; a < 4; a++) begin
         wait_strobe("t3_strobe");
         if (a == 0) begin
            check("t3_ack", 64'(req_ack_o), 64'h4);
            req_valid_i = 4'b0000;
         end else begin
            check($sformatf("t3_noack%0d", a), 64'(req_ack_o), 64'h0);
         end
         @(negedge clk_i);
         pulse(1'b0, 1'b1);
         if (a < 3) begin
            check($sformatf("t3_retry%0d", a), 64'(tx_start_strobe_o), 64'h1);
         end else begin
            check("t3_fail", 64'(fail_o), 64'h4);
            check("t3_done", 64'(done_o), 64'h0);
         end
      end
      settle();
      check_counts("t3", 4, 1, 0, 1);

      // Requester 3: fail, fail, succeed with payload stable throughout
      snap();
      req_valid_i = 4'b1000;
      for (int a = 0; a < 3; a++) begin
         wait_strobe("t4_strobe");
         if (a == 0) req_valid_i = 4'b0000;
         check($sformatf("t4_data%0d", a), tx_data_o, pay[3]);
         @(negedge clk_i);
         pulse(a == 2, a != 2);
      end
      check("t4_done",      64'(done_o), 64'h8);
      check("t4_data_done", tx_data_o,   pay[3]);
      settle();
      check_counts("t4", 3, 1, 1, 0);

      // Requester 1: success and failure together, success wins
      snap();
      req_valid_i = 4'b0010;
      wait_strobe("t5_strobe");
      req_valid_i = 4'b0000;
      @(negedge clk_i);
      pulse(1'b1, 1'b1);
      check("t5_done",   64'(done_o),            64'h2);
      check("t5_fail",   64'(fail_o),            64'h0);
      check("t5_strobe", 64'(tx_start_strobe_o), 64'h0);
      settle();
      check_counts("t5", 1, 1, 1, 0);

      // Requester 0, reset asserted mid-WAIT: frame abandoned silently
      req_valid_i = 4'b0001;
      wait_strobe("t6_strobe");
      req_valid_i = 4'b0000;
      repeat (4) @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check_all_zero("t6_rst");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      snap();
      repeat (3) @(negedge clk_i);
      pulse(1'b1, 1'b0);
      settle();
      check("t6_busy", 64'(busy_o), 64'h0);
      check_counts("t6", 0, 0, 0, 0);

`ifdef CAN_TX_SCHED_TIMEOUT_EN
      // No response at all: a new attempt every 101 cycles, fail after 4 attempts
      snap();
      req_valid_i = 4'b0100;
      wait_strobe("t7_strobe");
      req_valid_i = 4'b0000;
      for (int a = 0; a < 4; a++) begin
         int n;
         n = 0;
         do begin
            @(negedge clk_i);
            n++;
         end while (tx_start_strobe_o !== 1'b1 && fail_o == 4'b0000 && n < 300);
         check($sformatf("t7_gap%0d", a), 64'(n), 64'd101);
         if (a < 3) check($sformatf("t7_retry%0d", a), 64'(tx_start_strobe_o), 64'h1);
         else       check("t7_fail", 64'(fail_o), 64'h4);
      end
      settle();
      check_counts("t7", 4, 1, 0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
